program_loader: RTL
===================

// Module: program_loader
//
// PURPOSE
//   Bus-mastering program loader for the 8-bit machine. Accepts a byte stream over a
//   valid/ready handshake and writes it into Memory through the shared bus.
//   Uses the memory's address-latch / write-strobe sequence, holding the CPU halted
//   for the duration. Sits beside InstructionDecoder; the top level muxes its strobes
//   into the Control word and its bus_drive gates the tri-state bus driver.
//
// PARAMETERS
//   ADDR_W     4    memory address width; MEM_DEPTH = 2**ADDR_W bytes
//   DATA_W     8    bus / memory data width
//
// PORTS
//   clock          in   1         system clock, rising edge
//   reset          in   1         asynchronous, active-high
//   start          in   1         1-cycle pulse: begin a load (ignored while busy)
//   base_addr      in   ADDR_W    first memory address, sampled on start
//   length         in   ADDR_W+1  byte count, sampled on start (0..MEM_DEPTH)
//   in_data        in   DATA_W    stream byte
//   in_valid       in   1         stream byte valid
//   in_ready       out  1         loader accepts byte this cycle (in_valid&in_ready)
//   cpu_idle       in   1         decoder at instruction boundary, safe to steal bus
//   cpu_halt       out  1         request: decoder freezes and stops driving bus
//   bus_data       out  DATA_W    value loader drives onto bus
//   bus_drive      out  1         tri-state enable for bus_data
//   bus_in         in   DATA_W    bus value (read-back; used only with verify)
//   mem_write_addr out  1         memory latches bus as address on this edge
//   mem_write      out  1         memory stores bus at latched address on this edge
//   mem_read       out  1         memory drives bus (verify only, else 0)
//   busy           out  1         load in progress (state != IDLE)
//   done           out  1         1-cycle pulse: load finished
//   verify_error   out  1         sticky read-back mismatch flag
//
// BEHAVIOUR
//   Reset (async): state=IDLE; all outputs 0; counters/latches 0; verify_error=0.
//   States: IDLE, HALT_WAIT, WAIT_BYTE, ADDR, DATA, [VERIFY], DONE.
//   IDLE: start & length!=0 -> latch base_addr,length; idx=0 -> HALT_WAIT.
//         start & length==0 -> DONE directly (no halt, no writes).
//   HALT_WAIT: cpu_halt=1; cpu_idle -> WAIT_BYTE.
//   WAIT_BYTE: in_ready=1; in_valid -> latch in_data -> ADDR. No timeout.
//   ADDR: bus_drive=1, bus_data={zero-extend}(base+idx mod MEM_DEPTH), mem_write_addr=1.
//   DATA: bus_drive=1, bus_data=latched byte, mem_write=1; idx++.
//         -> VERIFY if enabled, else (idx==length ? DONE : WAIT_BYTE).
//   DONE: done=1 for one cycle; cpu_halt drops; -> IDLE.
//   cpu_halt=1 in every state from HALT_WAIT through DATA/VERIFY; 0 in IDLE, DONE.
//   Address wraps modulo MEM_DEPTH (base 0xE, length 4 -> 0xE,0xF,0x0,0x1).
//   Min 3 cycles/byte (4 with verify); in_ready high only in WAIT_BYTE.
//   bus_drive and mem_read never asserted in the same cycle; at most one strobe/cycle.
//   start while busy: ignored. Length and base changes mid-load: ignored.
//   Reset mid-load: abort immediately; memory holds bytes written so far.
//
// CONFIGURATION
//   LOADER_VERIFY_EN defined: after DATA, VERIFY state: mem_read=1, bus_drive=0;
//     bus_in sampled at edge; bus_in != byte -> verify_error=1 (sticky until next
//     accepted start); load continues. Next state per DATA rule.
//   Undefined: no VERIFY state; mem_read and verify_error tied 0; bus_in unused.
//
// TESTING
//   1. base=0x3,len=2, cpu_idle=1, bytes 0xA5,0x5A back-to-back -> writes [3]=A5,[4]=5A,
//      strobe order ADDR,DATA per byte, done 1 cycle, cpu_halt low after.
//   2. cpu_idle held 0 for 5 cycles after start -> cpu_halt=1, in_ready=0, no strobes
//      until cpu_idle rises.
//   3. base=0xE,len=4 -> addresses 0xE,0xF,0x0,0x1 on bus during mem_write_addr.
//   4. start with len=0 -> done next cycle, cpu_halt never 1, no strobes; second start
//      while busy mid-load -> ignored, original load completes.
//   5. reset asserted during DATA of byte 2 -> all outputs 0 same cycle, state IDLE.
//   6. (LOADER_VERIFY_EN) bench returns bus_in=0x00 for byte 0x77 -> verify_error=1,
//      stays 1 after done, cleared by next start.

Source files
------------

// File: rtl/program_loader.sv
// Bus-mastering program loader: streams bytes into memory through the shared bus with
// address-latch / write-strobe cycles while the CPU is halted. Read-back check via LOADER_VERIFY_EN.
module program_loader #(
  parameter int unsigned ADDR_W = 4,
  parameter int unsigned DATA_W = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W:0]   length,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              cpu_idle,
  output logic              cpu_halt,
  output logic [DATA_W-1:0] bus_data,
  output logic              bus_drive,
  input  logic [DATA_W-1:0] bus_in,
  output logic              mem_write_addr,
  output logic              mem_write,
  output logic              mem_read,
  output logic              busy,
  output logic              done,
  output logic              verify_error
);

  localparam int unsigned CNT_W = ADDR_W + 1;

  typedef enum logic [2:0] {
    S_IDLE, S_HALT_WAIT, S_WAIT_BYTE, S_ADDR, S_DATA, S_DONE
`ifdef LOADER_VERIFY_EN
    , S_VERIFY
`endif
  } state_t;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] base_q, base_nxt;
  logic [CNT_W-1:0]  len_q, len_nxt;
  logic [CNT_W-1:0]  idx_q, idx_nxt;
  logic [DATA_W-1:0] byte_q, byte_nxt;
  logic              clear_err;

  logic              in_ready_nxt, cpu_halt_nxt, bus_drive_nxt, busy_nxt, done_nxt;
  logic              mem_write_addr_nxt, mem_write_nxt, mem_read_nxt;
  logic [DATA_W-1:0] bus_data_nxt;
  logic [ADDR_W-1:0] addr_nxt;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state  <= S_IDLE;
      base_q <= '0;
      len_q  <= '0;
      idx_q  <= '0;
      byte_q <= '0;
    end else begin
      state  <= state_nxt;
      base_q <= base_nxt;
      len_q  <= len_nxt;
      idx_q  <= idx_nxt;
      byte_q <= byte_nxt;
    end
  end

  // Next state, then outputs decoded from the next state so they register in step with it
  always_comb begin
    state_nxt          = state;
    base_nxt           = base_q;
    len_nxt            = len_q;
    idx_nxt            = idx_q;
    byte_nxt           = byte_q;
    clear_err          = 1'b0;
    in_ready_nxt       = 1'b0;
    cpu_halt_nxt       = 1'b0;
    bus_drive_nxt      = 1'b0;
    bus_data_nxt       = '0;
    mem_write_addr_nxt = 1'b0;
    mem_write_nxt      = 1'b0;
    mem_read_nxt       = 1'b0;
    done_nxt           = 1'b0;

    case (state)
      S_IDLE: begin
        if (start) begin
          clear_err = 1'b1;
          if (length != '0) begin
            base_nxt  = base_addr;
            len_nxt   = length;
            idx_nxt   = '0;
            state_nxt = S_HALT_WAIT;
          end else begin
            state_nxt = S_DONE;
          end
        end
      end
      S_HALT_WAIT: if (cpu_idle) state_nxt = S_WAIT_BYTE;
      S_WAIT_BYTE: begin
        if (in_valid) begin
          byte_nxt  = in_data;
          state_nxt = S_ADDR;
        end
      end
      S_ADDR: state_nxt = S_DATA;
      S_DATA: begin
        idx_nxt = idx_q + CNT_W'(1);
`ifdef LOADER_VERIFY_EN
        state_nxt = S_VERIFY;
`else
        state_nxt = (idx_nxt == len_q) ? S_DONE : S_WAIT_BYTE;
`endif
      end
`ifdef LOADER_VERIFY_EN
      S_VERIFY: state_nxt = (idx_q == len_q) ? S_DONE : S_WAIT_BYTE;
`endif
      S_DONE: state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase

    addr_nxt = ADDR_W'(base_nxt + idx_nxt[ADDR_W-1:0]);
    busy_nxt = (state_nxt != S_IDLE);

    case (state_nxt)
      S_HALT_WAIT: cpu_halt_nxt = 1'b1;
      S_WAIT_BYTE: begin
        cpu_halt_nxt = 1'b1;
        in_ready_nxt = 1'b1;
      end
      S_ADDR: begin
        cpu_halt_nxt       = 1'b1;
        bus_drive_nxt      = 1'b1;
        bus_data_nxt       = DATA_W'(addr_nxt);
        mem_write_addr_nxt = 1'b1;
      end
      S_DATA: begin
        cpu_halt_nxt  = 1'b1;
        bus_drive_nxt = 1'b1;
        bus_data_nxt  = byte_nxt;
        mem_write_nxt = 1'b1;
      end
`ifdef LOADER_VERIFY_EN
      S_VERIFY: begin
        cpu_halt_nxt = 1'b1;
        mem_read_nxt = 1'b1;
      end
`endif
      S_DONE: done_nxt = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      in_ready       <= 1'b0;
      cpu_halt       <= 1'b0;
      bus_data       <= '0;
      bus_drive      <= 1'b0;
      mem_write_addr <= 1'b0;
      mem_write      <= 1'b0;
      mem_read       <= 1'b0;
      busy           <= 1'b0;
      done           <= 1'b0;
    end else begin
      in_ready       <= in_ready_nxt;
      cpu_halt       <= cpu_halt_nxt;
      bus_data       <= bus_data_nxt;
      bus_drive      <= bus_drive_nxt;
      mem_write_addr <= mem_write_addr_nxt;
      mem_write      <= mem_write_nxt;
      mem_read       <= mem_read_nxt;
      busy           <= busy_nxt;
      done           <= done_nxt;
    end
  end

`ifdef LOADER_VERIFY_EN
  // Sticky read-back mismatch; bus_in is sampled at the edge that ends VERIFY
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      verify_error <= 1'b0;
    end else if (clear_err) begin
      verify_error <= 1'b0;
    end else if (state == S_VERIFY && bus_in != byte_q) begin
      verify_error <= 1'b1;
    end
  end
`else
  logic unused_inputs;
  assign unused_inputs = ^{bus_in, clear_err};
  assign verify_error  = 1'b0;
`endif

endmodule
